// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory port of the prefetch queue: a valid/ready request
// channel and an in-order, always-accepted response channel.
interface fetch_prefetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with decoupled imem requests, an in-order PC tag FIFO and
// a DEPTH-entry instruction queue; redirects flush and drop stale replies.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PCSrcE,
    input  logic [XLEN-1:0]        PCTargetE,
    input  logic                   StallF,
    fetch_prefetch_queue_if.master imem,
    output logic                   ValidF,
    output logic [31:0]            InstrF,
    output logic [XLEN-1:0]        PCF,
    output logic [XLEN-1:0]        PCPlus4F
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic            r_run;
    logic [XLEN-1:0] r_pc;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [OW-1:0]   r_out;
    logic [OW-1:0]   r_drop;
    logic [TW-1:0]   r_trd;
    logic [TW-1:0]   r_twr;
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];
    logic [XLEN-1:0] r_tag     [MAX_OUTSTANDING];

    logic        w_req;
    logic        w_acc;
    logic        w_rsp;
    logic        w_drop_now;
    logic        w_enq;
    logic        w_pop;
    logic [31:0] w_used;

    function automatic logic [TW-1:0] tnext(input logic [TW-1:0] p);
        if (32'(p) == MAX_OUTSTANDING - 1) return '0;
        return p + TW'(1);
    endfunction

    // Credit counts queued entries plus live (non-dropped) requests.
    assign w_used     = 32'(r_count) + 32'(r_out) - 32'(r_drop);
    assign w_req      = r_run && !PCSrcE
                        && (32'(r_out) < MAX_OUTSTANDING)
                        && (w_used < DEPTH);
    assign w_acc      = w_req && imem.imem_req_ready;
    assign w_rsp      = imem.imem_rsp_valid && (r_out != '0);
    assign w_drop_now = w_rsp && (r_drop != '0);
    assign w_enq      = w_rsp && (r_drop == '0) && !PCSrcE;
    assign w_pop      = ValidF && !StallF && !PCSrcE;

    assign imem.imem_req_valid = w_req;
    assign imem.imem_req_addr  = r_pc;

    assign ValidF   = (r_count != '0);
    assign InstrF   = ValidF ? r_q_instr[r_rd] : 32'h0000_0013;
    assign PCF      = ValidF ? r_q_pc[r_rd] : '0;
    assign PCPlus4F = ValidF ? r_q_pc[r_rd] + XLEN'(4) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_trd   <= '0;
            r_twr   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_pc  <= r_pc + XLEN'(4);
                r_twr <= tnext(r_twr);
            end
            if (w_rsp) r_trd <= tnext(r_trd);
            r_out <= r_out + OW'(w_acc) - OW'(w_rsp);
            if (PCSrcE) begin
                r_pc    <= PCTargetE;
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_drop  <= r_out - OW'(w_rsp);
            end else begin
                if (w_enq) r_wr <= r_wr + AW'(1);
                if (w_pop) r_rd <= r_rd + AW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
                if (w_drop_now) r_drop <= r_drop - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_tag[r_twr] <= r_pc;
        if (w_enq) begin
            r_q_pc[r_wr]    <= r_tag[r_trd];
            r_q_instr[r_wr] <= imem.imem_rsp_data;
        end
    end

    a_rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst)
        !(imem.imem_rsp_valid && (r_out == '0))
    );
endmodule
